ysyx_22040127_sram_resp: RTL and testbench

- AXI4-Lite slave memory responder: the memory-side end of the core's instruction-fetch and load/store interface.
- Serves 64-bit-data read and write requests from an IFU/LSU master.
- Backed by an internal doubleword array mapped at BASE.
- Inserts a programmable response latency so the pipeline's handshakes are exercised against a non-ideal memory.

---
 rtl/ysyx_22040127_sram_resp.sv | 231 +++++++++++++++++++++++
 tb/tb_ysyx_22040127_sram_resp.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040127_sram_resp.sv
// ysyx_22040127_sram_resp
// AXI4-Lite slave memory responder. It serves 64-bit reads and writes from an
// IFU/LSU master out of an internal doubleword array mapped at BASE. It handles
// one transaction at a time and adds a programmable response latency.
// Optional build macro SRAM_RAND_DELAY_EN adds 0..7 cycles of LFSR jitter on
// top of LAT at every wait-state entry.
module ysyx_22040127_sram_resp #(
  parameter int unsigned        ADDR_W = 32,
  parameter int unsigned        DEPTH  = 1024,
  parameter logic [ADDR_W-1:0]  BASE   = 32'h80000000,
  parameter int unsigned        LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LAT + 8) + 1;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH) << 3;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RD_WAIT    = 3'd1;
  localparam logic [2:0] RD_RESP    = 3'd2;
  localparam logic [2:0] WR_COLLECT = 3'd3;
  localparam logic [2:0] WR_WAIT    = 3'd4;
  localparam logic [2:0] WR_RESP    = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [63:0]       mem [DEPTH];

  logic [2:0]        state;
  logic              grant;
  logic              aw_got;
  logic              w_got;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wstrb_q;
  logic [CNT_W-1:0]  cnt;
  logic              decoded;
  logic [IDX_W-1:0]  idx_q;
  logic              in_range_q;

  logic [ADDR_W-1:0] offset;
  logic              addr_in_range;
  logic [IDX_W-1:0]  addr_idx;
  logic [CNT_W-1:0]  wait_load;
  logic              conflict;
  logic              ar_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              wait_done;
  logic              wr_commit;

  // An address below BASE wraps to a huge offset, so one unsigned compare
  // covers both ends of the window.
  assign offset        = addr_q - BASE;
  assign addr_in_range = ({1'b0, offset} < SPAN);
  assign addr_idx      = offset[IDX_W+2:3];

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1, supplies the latency jitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign wait_load = CNT_W'(LAT - 1) + CNT_W'(lfsr[2:0]);
`else
  assign wait_load = CNT_W'(LAT - 1);
`endif

  assign conflict  = arvalid & (awvalid | wvalid);
  assign ar_hs     = arvalid & arready;
  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign wait_done = decoded && (cnt == '0);
  assign wr_commit = (state == WR_WAIT) && wait_done && in_range_q;

  // Ready generation: in IDLE the arbitration loser sees ready low; while a
  // write is being collected only the still-missing channel is ready.
  always_comb begin
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          arready = !(conflict && grant);
          awready = !(conflict && !grant);
          wready  = !(conflict && !grant);
        end
        WR_COLLECT: begin
          awready = !aw_got;
          wready  = !w_got;
        end
        default: ;
      endcase
    end
  end

  // Transaction FSM. The first wait cycle registers the address decode, then
  // the counter runs down. Payload and valid stay put until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt        <= '0;
      decoded    <= 1'b0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      rdata      <= '0;
      rresp      <= RESP_OKAY;
      rvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
      bvalid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            addr_q  <= araddr;
            grant   <= ~grant;
            cnt     <= wait_load;
            decoded <= 1'b0;
            state   <= RD_WAIT;
          end else if (aw_hs || w_hs) begin
            grant  <= ~grant;
            aw_got <= aw_hs && !w_hs;
            w_got  <= w_hs && !aw_hs;
            if (aw_hs) addr_q <= awaddr;
            if (w_hs) begin
              wdata_q <= wdata;
              wstrb_q <= wstrb;
            end
            if (aw_hs && w_hs) begin
              cnt     <= wait_load;
              decoded <= 1'b0;
              state   <= WR_WAIT;
            end else begin
              state <= WR_COLLECT;
            end
          end
        end
        WR_COLLECT: begin
          if (aw_hs) begin
            addr_q <= awaddr;
            aw_got <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            w_got   <= 1'b1;
          end
          if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            cnt     <= wait_load;
            decoded <= 1'b0;
            state   <= WR_WAIT;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (!decoded) begin
            decoded    <= 1'b1;
            idx_q      <= addr_idx;
            in_range_q <= addr_in_range;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (state == RD_WAIT) begin
            rdata  <= in_range_q ? mem[idx_q] : 64'd0;
            rresp  <= in_range_q ? RESP_OKAY : RESP_SLVERR;
            rvalid <= 1'b1;
            state  <= RD_RESP;
          end else begin
            bresp  <= in_range_q ? RESP_OKAY : RESP_SLVERR;
            bvalid <= 1'b1;
            state  <= WR_RESP;
          end
        end
        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-masked array write, committed on the same edge that raises bvalid.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_sram_resp.sv
// tb_ysyx_22040127_sram_resp
// Directed scenarios plus randomized traffic against a word-array reference
// model. The model predicts data, response codes, latency and the read/write
// winner of simultaneous requests.
module tb_ysyx_22040127_sram_resp;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 1;
  localparam logic [31:0] BASE  = 32'h80000000;

  logic        clk;
  logic        rst_n;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model [DEPTH];
  bit          write_next;
  logic [63:0] d;

  ysyx_22040127_sram_resp #(
    .ADDR_W (32),
    .DEPTH  (DEPTH),
    .BASE   (BASE),
    .LAT    (LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit inRange(input logic [31:0] a);
    longint unsigned la = 64'(a);
    longint unsigned lb = 64'(BASE);
    return (la >= lb) && (la < lb + 64'(8 * DEPTH));
  endfunction

  function automatic int wordIdx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  task automatic doReset();
    rst_n   = 1'b0;
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    rready  = 1'b0;
    bready  = 1'b0;
    araddr  = '0;
    awaddr  = '0;
    wdata   = '0;
    wstrb   = '0;
    #2;
    checkOutput("rst_arready", arready, 0);
    checkOutput("rst_awready", awready, 0);
    checkOutput("rst_wready", wready, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_bvalid", bvalid, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_rresp", rresp, 0);
    checkOutput("rst_bresp", bresp, 0);
    tick();
    tick();
    rst_n      = 1'b1;
    write_next = 1'b0;
    #1;
    checkOutput("idle_arready", arready, 1);
    checkOutput("idle_awready", awready, 1);
    checkOutput("idle_wready", wready, 1);
  endtask

  // Full read transaction; rready is held low for 'hold' cycles once rvalid rises.
  task automatic readWord(input logic [31:0] addr, input int hold, output logic [63:0] data);
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
    int          n;
    if (inRange(addr)) begin
      exp_d = model[wordIdx(addr)];
      exp_r = 2'b00;
    end else begin
      exp_d = 64'd0;
      exp_r = 2'b10;
    end
    araddr  = addr;
    arvalid = 1'b1;
    #1;
    checkOutput("rd_arready", arready, 1);
    tick();
    arvalid    = 1'b0;
    write_next = ~write_next;
    n = 0;
    while (!rvalid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("rd_latency", n, LAT + 1);
    for (int h = 0; h <= hold; h++) begin
      checkOutput("rd_rvalid", rvalid, 1);
      checkOutput("rd_rdata", rdata, exp_d);
      checkOutput("rd_rresp", rresp, exp_r);
      if (h < hold) tick();
    end
    data   = rdata;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checkOutput("rd_clear", rvalid, 0);
  endtask

  // Full write transaction. lead > 0: W goes that many cycles before AW;
  // lead < 0: AW goes first; lead == 0: both together.
  task automatic writeWord(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input int lead, input int hold);
    logic [1:0] exp_b;
    int         n;
    int         al;
    al    = (lead < 0) ? -lead : lead;
    exp_b = inRange(addr) ? 2'b00 : 2'b10;
    if (lead >= 0) begin
      wdata  = data;
      wstrb  = strb;
      wvalid = 1'b1;
    end
    if (lead <= 0) begin
      awaddr  = addr;
      awvalid = 1'b1;
    end
    #1;
    checkOutput("wr_first_ready", (lead >= 0) ? wready : awready, 1);
    tick();
    write_next = ~write_next;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    if (lead != 0) begin
      for (int k = 1; k <= al; k++) begin
        checkOutput("collect_done_ready", (lead > 0) ? wready : awready, 0);
        checkOutput("collect_open_ready", (lead > 0) ? awready : wready, 1);
        if (k < al) tick();
      end
      if (lead > 0) begin
        awaddr  = addr;
        awvalid = 1'b1;
      end else begin
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
      end
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
    n = 0;
    while (!bvalid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("wr_latency", n, LAT + 1);
    if (inRange(addr)) begin
      for (int b = 0; b < 8; b++) begin
        if (strb[b]) model[wordIdx(addr)][8*b +: 8] = data[8*b +: 8];
      end
    end
    for (int h = 0; h <= hold; h++) begin
      checkOutput("wr_bvalid", bvalid, 1);
      checkOutput("wr_bresp", bresp, exp_b);
      if (h < hold) tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checkOutput("wr_clear", bvalid, 0);
  endtask

  // Presents read and write at once, checks which side the model expects to
  // win, then withdraws both before the edge so nothing is accepted.
  task automatic checkConflict(input bit with_w);
    araddr  = BASE;
    arvalid = 1'b1;
    awaddr  = BASE + 32'd8;
    awvalid = 1'b1;
    wvalid  = with_w;
    #1;
    checkOutput("arb_arready", arready, !write_next);
    checkOutput("arb_awready", awready, write_next);
    checkOutput("arb_wready", wready, write_next);
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    case ($urandom_range(0, 11))
      0:       a = BASE - 32'd8;
      1:       a = BASE + 32'(8 * DEPTH) + 32'($urandom_range(0, 7));
      default: a = BASE + 32'(8 * $urandom_range(0, 15)) + 32'($urandom_range(0, 7));
    endcase
    return a;
  endfunction

  task automatic applyStimulus(input int count);
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    readWord(randAddr(), $urandom_range(0, 3), d);
        2, 3:    writeWord(randAddr(), {$urandom, $urandom}, 8'($urandom),
                           $urandom_range(0, 4) - 2, $urandom_range(0, 2));
        default: checkConflict(1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  initial begin
    write_next = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;
    doReset();

    for (int i = 0; i < 16; i++) writeWord(BASE + 32'(8 * i), 64'd0, 8'hFF, 0, 0);
    writeWord(BASE + 32'(8 * (DEPTH - 1)), 64'h0BAD_F00D_DEAD_BEEF, 8'hFF, 0, 0);
    writeWord(BASE, 64'h1122334455667788, 8'hFF, 0, 0);
    doReset();

    readWord(BASE, 0, d);
    checkOutput("preload_rdata", d, 64'h1122334455667788);

    writeWord(BASE + 32'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0);
    readWord(BASE + 32'd8, 0, d);
    checkOutput("strb_readback", d, 64'h00000000FFFFFFFF);

    writeWord(BASE + 32'd24, 64'hCAFE_BABE_0123_4567, 8'hFF, 3, 0);
    writeWord(BASE + 32'd32, 64'hA5A5_5A5A_F0F0_0F0F, 8'hA5, -2, 2);
    writeWord(BASE + 32'd24, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1, 0);
    readWord(BASE + 32'd24, 1, d);
    checkOutput("zero_strb_readback", d, 64'hCAFE_BABE_0123_4567);

    readWord(32'h7FFFFFF8, 0, d);
    writeWord(32'h80002000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1);
    readWord(BASE, 0, d);
    checkOutput("oor_word0_intact", d, 64'h1122334455667788);
    readWord(BASE + 32'(8 * (DEPTH - 1)), 0, d);
    checkOutput("last_word", d, 64'h0BAD_F00D_DEAD_BEEF);

    readWord(BASE + 32'd32, 5, d);

    doReset();
    araddr  = BASE;
    arvalid = 1'b1;
    awaddr  = BASE + 32'd16;
    awvalid = 1'b1;
    wdata   = 64'h0F1E_2D3C_4B5A_6978;
    wstrb   = 8'hFF;
    wvalid  = 1'b1;
    #1;
    checkOutput("both_arready", arready, 1);
    checkOutput("both_awready", awready, 0);
    checkOutput("both_wready", wready, 0);
    tick();
    arvalid = 1'b0;
    checkOutput("rdwait_awready", awready, 0);
    begin
      int n = 0;
      while (!rvalid && n < 40) begin
        tick();
        n++;
      end
      checkOutput("both_rd_latency", n, LAT + 1);
    end
    checkOutput("both_rdata", rdata, 64'h1122334455667788);
    rready = 1'b1;
    #1;
    checkOutput("rresp_awready", awready, 0);
    tick();
    rready = 1'b0;
    checkOutput("both_rclear", rvalid, 0);
    checkOutput("after_r_awready", awready, 1);
    checkOutput("after_r_wready", wready, 1);
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    model[2] = 64'h0F1E_2D3C_4B5A_6978;
    begin
      int n = 0;
      while (!bvalid && n < 40) begin
        tick();
        n++;
      end
      checkOutput("both_wr_latency", n, LAT + 1);
    end
    checkOutput("both_bresp", bresp, 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    write_next = 1'b0;
    checkConflict(1'b1);
    readWord(BASE + 32'd16, 0, d);
    checkOutput("both_wr_readback", d, 64'h0F1E_2D3C_4B5A_6978);
    checkConflict(1'b1);
    checkConflict(1'b0);

    awaddr  = BASE + 32'd24;
    awvalid = 1'b1;
    wdata   = 64'h1111_2222_3333_4444;
    wstrb   = 8'hFF;
    wvalid  = 1'b1;
    #1;
    checkOutput("abort_awready", awready, 1);
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkOutput("abort_bvalid", bvalid, 0);
    checkOutput("abort_awready_rst", awready, 0);
    doReset();
    readWord(BASE + 32'd24, 0, d);
    checkOutput("abort_word_intact", d, 64'hCAFE_BABE_0123_4567);

    applyStimulus(120);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
